// File: rtl/max6682_spi_responder.sv
// SPI mode-0 slave that emulates a MAX6682 sensor: shifts Value_i out on MISO and captures MOSI.
// Build option: define MAX6682_SPI_RESPONDER_LSB_FIRST_EN for LSB-first shifting in both directions.
module max6682_spi_responder #(
   parameter int unsigned FrameBits  = 16,
   parameter int unsigned SyncStages = 2
) (
   input  logic                 Clk_i,
   input  logic                 Reset_i,
   input  logic                 SCK_i,
   input  logic                 CS_n_i,
   input  logic                 MOSI_i,
   output logic                 MISO_o,
   output logic                 MISO_OE_o,
   input  logic [FrameBits-1:0] Value_i,
   output logic [FrameBits-1:0] RxData_o,
   output logic                 RxValid_o,
   output logic                 Abort_o,
   output logic                 Busy_o
);

   localparam int unsigned CntW = $clog2(FrameBits) + 1;

   typedef enum logic [1:0] {StIdle, StShift, StTail} state_e;

   logic [SyncStages-1:0] sck_sync, cs_sync, mosi_sync;
   logic                  sck_d, cs_d, mosi_d;
   logic                  sck_s, cs_s;
   logic                  sck_rise, sck_fall, cs_rise, cs_fall;

   state_e                state_q, state_d;
   logic [FrameBits-1:0]  tx_q, tx_d;
   logic [FrameBits-1:0]  rx_q, rx_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  active_q, active_d;
   logic [FrameBits-1:0]  rxdata_q, rxdata_d;
   logic                  valid_q, valid_d;
   logic                  abort_q, abort_d;

   logic [FrameBits-1:0]  tx_shifted, rx_shifted;
   logic                  tx_out;

   // CS_n chain resets low so a CS_n held low through reset needs a high phase first.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         sck_sync  <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b0;
         mosi_d    <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SyncStages-2:0], SCK_i};
         cs_sync   <= {cs_sync[SyncStages-2:0], CS_n_i};
         mosi_sync <= {mosi_sync[SyncStages-2:0], MOSI_i};
         sck_d     <= sck_sync[SyncStages-1];
         cs_d      <= cs_sync[SyncStages-1];
         mosi_d    <= mosi_sync[SyncStages-1];
      end
   end

   assign sck_s    = sck_sync[SyncStages-1];
   assign cs_s     = cs_sync[SyncStages-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_rise  = cs_s & ~cs_d;
   assign cs_fall  = ~cs_s & cs_d;

   // MISO is the outgoing end of tx_q; zeros shift in, so bits past the frame read as 0.
`ifdef MAX6682_SPI_RESPONDER_LSB_FIRST_EN
   assign tx_out     = tx_q[0];
   assign tx_shifted = {1'b0, tx_q[FrameBits-1:1]};
   assign rx_shifted = {mosi_d, rx_q[FrameBits-1:1]};
`else
   assign tx_out     = tx_q[FrameBits-1];
   assign tx_shifted = {tx_q[FrameBits-2:0], 1'b0};
   assign rx_shifted = {rx_q[FrameBits-2:0], mosi_d};
`endif

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      rxdata_d = rxdata_q;
      valid_d  = 1'b0;
      abort_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d     = '0;
            active_d = 1'b0;
            if (cs_fall) begin
               tx_d     = Value_i;
               cnt_d    = '0;
               active_d = 1'b1;
               state_d  = StShift;
            end
         end
         StShift: begin
            // CS_n edges win over a coincident SCK edge.
            if (cs_rise) begin
               abort_d  = 1'b1;
               active_d = 1'b0;
               tx_d     = '0;
               state_d  = StIdle;
            end else if (sck_rise) begin
               rx_d  = rx_shifted;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(FrameBits - 1)) begin
                  state_d = StTail;
               end
            end else if (sck_fall) begin
               tx_d = tx_shifted;
            end
         end
         StTail: begin
            if (cs_rise) begin
               rxdata_d = rx_q;
               valid_d  = 1'b1;
               active_d = 1'b0;
               tx_d     = '0;
               state_d  = StIdle;
            end else if (sck_fall) begin
               tx_d = '0;
            end
         end
         default: begin
            state_d  = StIdle;
            active_d = 1'b0;
            tx_d     = '0;
         end
      endcase
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q  <= StIdle;
         tx_q     <= '0;
         rx_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         rxdata_q <= '0;
         valid_q  <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         rxdata_q <= rxdata_d;
         valid_q  <= valid_d;
         abort_q  <= abort_d;
      end
   end

   assign MISO_o    = tx_out & active_q;
   assign MISO_OE_o = active_q;
   assign Busy_o    = active_q;
   assign RxData_o  = rxdata_q;
   assign RxValid_o = valid_q;
   assign Abort_o   = abort_q;

endmodule

// File: tb/tb_max6682_spi_responder.sv
// Bench for max6682_spi_responder: table vectors, hand sequences and random frames vs a bit-level model.
// Honours MAX6682_SPI_RESPONDER_LSB_FIRST_EN to match the LSB-first build.
module tb_max6682_spi_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, miso_oe, rx_valid, abort_p, busy;
   logic [15:0] value = 16'h0000;
   logic [15:0] rx_data;

   int checks = 0;
   int errors = 0;
   int valid_cycles = 0;
   int abort_cycles = 0;

   always #5 clk = ~clk;

   max6682_spi_responder #(.FrameBits(16), .SyncStages(2)) dut (
      .Clk_i    (clk),
      .Reset_i  (rst),
      .SCK_i    (sck),
      .CS_n_i   (cs_n),
      .MOSI_i   (mosi),
      .MISO_o   (miso),
      .MISO_OE_o(miso_oe),
      .Value_i  (value),
      .RxData_o (rx_data),
      .RxValid_o(rx_valid),
      .Abort_o  (abort_p),
      .Busy_o   (busy)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) valid_cycles++;
         if (abort_p) abort_cycles++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: bit i of the frame as the master sees it, and the word assembled from MOSI.
   function automatic logic [31:0] model_read(input logic [15:0] v, input int n);
      logic [31:0] r = '0;
      logic        b;
      for (int i = 0; i < n; i++) begin
`ifdef MAX6682_SPI_RESPONDER_LSB_FIRST_EN
         b = (i < 16) ? v[i] : 1'b0;
`else
         b = (i < 16) ? v[15-i] : 1'b0;
`endif
         r = {r[30:0], b};
      end
      return r;
   endfunction

   function automatic logic [15:0] model_rx(input logic [31:0] m, input int n);
      logic [15:0] r = '0;
      for (int i = 0; i < 16; i++) begin
`ifdef MAX6682_SPI_RESPONDER_LSB_FIRST_EN
         r[i] = m[n-1-i];
`else
         r[15-i] = m[n-1-i];
`endif
      end
      return r;
   endfunction

   // Clocks n SCK periods (8 low / 8 high Clk cycles); MOSI sent from bit n-1 downward.
   task automatic sck_bits(input logic [31:0] m, input int n, input int chg_at,
                           input logic [15:0] chg_val, output logic [31:0] rd);
      rd = '0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (2) @(negedge clk);
         mosi = m[n-1-i];
         repeat (6) @(negedge clk);
         rd  = {rd[30:0], miso};
         sck = 1'b1;
         if (i + 1 == chg_at) value = chg_val;
         repeat (8) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [15:0] v, input logic [31:0] m, input int n,
                            input int chg_at, input logic [15:0] chg_val,
                            output logic [31:0] rd, output logic oe_late, output logic busy_late);
      @(negedge clk);
      value = v;
      cs_n  = 1'b0;
      repeat (8) @(negedge clk);
      sck_bits(m, n, chg_at, chg_val, rd);
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      oe_late = miso_oe;
      repeat (6) @(negedge clk);
      busy_late = busy;
   endtask

   typedef struct {
      logic [15:0] value;
      logic [31:0] mosi;
      int          nbits;
      int          chg_at;
      logic [15:0] chg_val;
      logic [31:0] exp_rd;
      logic [15:0] exp_rx;
      int          exp_valid;
      int          exp_abort;
   } vec_t;

`ifdef MAX6682_SPI_RESPONDER_LSB_FIRST_EN
   localparam int NVec = 2;
`else
   localparam int NVec = 5;
`endif
   vec_t vecs [NVec];

   initial begin
      logic [31:0] rd;
      logic        oe_late, busy_late;
      int          v0, a0, n;
      logic [15:0] rv, exp_rx;
      logic [31:0] rm;

`ifdef MAX6682_SPI_RESPONDER_LSB_FIRST_EN
      vecs[0] = '{16'h0001, 32'h8000, 16, 0, 16'h0, 32'h8000, 16'h0001, 1, 0};
      vecs[1] = '{16'hA5C3, 32'h1234, 16, 0, 16'h0, 32'hC3A5, 16'h2C48, 1, 0};
`else
      vecs[0] = '{16'hA5C3, 32'h1234,  16, 0, 16'h0,    32'hA5C3,  16'h1234, 1, 0};
      vecs[1] = '{16'hFFFF, 32'h00AB,  9,  0, 16'h0,    32'h01FF,  16'h1234, 0, 1};
      vecs[2] = '{16'h8001, 32'hBEEF5, 20, 0, 16'h0,    32'h80010, 16'hBEEF, 1, 0};
      vecs[3] = '{16'h0F0F, 32'h5555,  16, 3, 16'hF0F0, 32'h0F0F,  16'h5555, 1, 0};
      vecs[4] = '{16'hF0F0, 32'h00FF,  16, 0, 16'h0,    32'hF0F0,  16'h00FF, 1, 0};
`endif

      repeat (4) @(negedge clk);
      check("reset_miso", {31'b0, miso}, 32'h0);
      check("reset_oe", {31'b0, miso_oe}, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_rxdata", {16'b0, rx_data}, 32'h0);
      check("reset_valid", {31'b0, rx_valid}, 32'h0);
      check("reset_abort", {31'b0, abort_p}, 32'h0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      for (int k = 0; k < NVec; k++) begin
         v0 = valid_cycles;
         a0 = abort_cycles;
         run_frame(vecs[k].value, vecs[k].mosi, vecs[k].nbits, vecs[k].chg_at, vecs[k].chg_val,
                   rd, oe_late, busy_late);
         check($sformatf("vec%0d_miso_word", k), rd, vecs[k].exp_rd);
         check($sformatf("vec%0d_rxdata", k), {16'b0, rx_data}, {16'b0, vecs[k].exp_rx});
         check($sformatf("vec%0d_valid_cycles", k), valid_cycles - v0, vecs[k].exp_valid);
         check($sformatf("vec%0d_abort_cycles", k), abort_cycles - a0, vecs[k].exp_abort);
         check($sformatf("vec%0d_oe_after_cs", k), {31'b0, oe_late}, 32'h0);
         check($sformatf("vec%0d_busy_after", k), {31'b0, busy_late}, 32'h0);
      end

      // Reset mid-frame with CS_n held low, then recovery.
      v0 = valid_cycles;
      a0 = abort_cycles;
      @(negedge clk);
      value = 16'hBEEF;
      cs_n  = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_busy_before", {31'b0, busy}, 32'h1);
      sck_bits(32'h15, 5, 0, 16'h0, rd);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_oe", {31'b0, miso_oe}, 32'h0);
      check("midrst_busy", {31'b0, busy}, 32'h0);
      check("midrst_miso", {31'b0, miso}, 32'h0);
      check("midrst_rxdata", {16'b0, rx_data}, 32'h0);
      sck_bits(32'hF, 4, 0, 16'h0, rd);
      check("midrst_ignored_busy", {31'b0, busy}, 32'h0);
      check("midrst_ignored_oe", {31'b0, miso_oe}, 32'h0);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_valid", valid_cycles - v0, 0);
      check("midrst_no_abort", abort_cycles - a0, 0);
      run_frame(16'h5A5A, 32'hC3C3, 16, 0, 16'h0, rd, oe_late, busy_late);
      check("midrst_recover_miso", rd, model_read(16'h5A5A, 16));
      check("midrst_recover_rx", {16'b0, rx_data}, {16'b0, model_rx(32'hC3C3, 16)});

      // Random frames against the model; short frames must leave RxData_o alone.
      exp_rx = rx_data;
      exp_rx = model_rx(32'hC3C3, 16);
      for (int k = 0; k < 12; k++) begin
         n  = $urandom_range(1, 20);
         rv = 16'($urandom);
         rm = 32'($urandom) & ((32'h1 << n) - 1);
         v0 = valid_cycles;
         a0 = abort_cycles;
         run_frame(rv, rm, n, 0, 16'h0, rd, oe_late, busy_late);
         if (n >= 16) exp_rx = model_rx(rm, n);
         check($sformatf("rnd%0d_miso_word", k), rd, model_read(rv, n));
         check($sformatf("rnd%0d_rxdata", k), {16'b0, rx_data}, {16'b0, exp_rx});
         check($sformatf("rnd%0d_valid", k), valid_cycles - v0, (n >= 16) ? 1 : 0);
         check($sformatf("rnd%0d_abort", k), abort_cycles - a0, (n >= 16) ? 0 : 1);
         check($sformatf("rnd%0d_oe_after_cs", k), {31'b0, oe_late}, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
